hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core. It drives stall and flush for the IF/ID, ID/EX and EX/MEM pipeline registers and the PC write enable.
- Handles three cases: load-use hazards (one bubble), control hazards (branch resolved in EX, jump decoded in ID) and multi-cycle data-memory accesses (full freeze until dmem_ready).
- Keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use bubbles,
// branch/jump flushes and data-memory freezes, plus performance counters.
//
// state    | meaning
// RUN      | pipeline advancing normally (hazard rules evaluated each cycle)
// MEM_WAIT | data-memory access outstanding; whole pipeline frozen
module hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WW = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_MEM_WAIT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic            freeze, lu;
  logic            stall_evt, flush_evt, timeout_set;

  assign freeze = mem_access & ~dmem_ready;
  assign lu     = ex_MemRead & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_nxt   = RUN;
      wait_nxt    = '0;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_nxt   = MEM_WAIT;
      if (state == RUN)
        wait_nxt = WW'(1);
      else if (wait_cnt != WAIT_MAX)
        wait_nxt = wait_cnt + 1'b1;
    end else begin
      state_nxt = RUN;
      wait_nxt  = '0;
      // Masked lower-priority hazards are dropped, not queued.
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_evt  = 1'b1;
      end else if (lu) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        stall_evt  = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
        flush_evt  = 1'b1;
      end
    end
  end

  assign timeout_set = ~reset & freeze & (wait_nxt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (stall_evt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
      if (timeout_set)
        mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (CNT_W=2, MAX_MEM_WAIT=4) with a
// queue-based scoreboard: the driver pushes expectations, a monitor checks them.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 0, id_jump = 0, ex_MemRead = 0, ex_branch_taken = 0;
  logic       mem_access = 0, dmem_ready = 1;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
  logic [1:0] stall_cnt, flush_cnt;
  logic       mem_timeout;

  hazard_ctrl #(.CNT_W(2), .MAX_MEM_WAIT(4)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
  localparam logic [5:0] C_RST = 6'b001010;
  localparam logic [5:0] C_DEF = 6'b110101;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_LU  = 6'b000111;
  localparam logic [5:0] C_JMP = 6'b111101;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urt, jmp, mrd;
    logic [4:0] xrt;
    logic       br, macc, rdy;
    logic [5:0] ctl;
    logic [1:0] sc, fc;
    logic       tmo;
  } vec_t;

  typedef struct {
    int         idx;
    logic [5:0] ctl;
    logic [1:0] sc, fc;
    logic       tmo;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic urt,
                              logic jmp, logic mrd, logic [4:0] xrt, logic br,
                              logic macc, logic rdy, logic [5:0] ctl,
                              logic [1:0] sc, logic [1:0] fc, logic tmo);
    vec_t v;
    v = '{rst, rs, rt, urt, jmp, mrd, xrt, br, macc, rdy, ctl, sc, fc, tmo};
    return v;
  endfunction

  function automatic void chk(string name, int idx, logic [5:0] act, logic [5:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, req);
    end
  endfunction

  // Counter/flag columns are the values visible during the cycle, i.e. before
  // that cycle's own event is registered.
  initial begin
    //          rst rs  rt  urt jmp mrd xrt br macc rdy ctl    sc fc tmo
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, 0, 0, 0)); // 0
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DEF, 0, 0, 0));
    tbl.push_back(mk(0, 8, 0, 0, 0, 1, 8, 0, 0, 1, C_LU,  0, 0, 0)); // lu on rs
    tbl.push_back(mk(0, 8, 0, 0, 0, 0, 8, 0, 0, 1, C_DEF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_DEF, 1, 0, 0)); // load to $0
    tbl.push_back(mk(0, 3, 9, 1, 0, 1, 9, 0, 0, 1, C_LU,  1, 0, 0)); // lu on rt
    tbl.push_back(mk(0, 3, 9, 0, 0, 1, 9, 0, 0, 1, C_DEF, 2, 0, 0)); // rt not read
    tbl.push_back(mk(0, 8, 0, 0, 0, 1, 8, 1, 0, 1, C_BR,  2, 0, 0)); // branch over lu
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DEF, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_JMP, 2, 1, 0)); // 10 jump
    tbl.push_back(mk(0, 8, 0, 0, 1, 1, 8, 0, 0, 1, C_LU,  2, 2, 0)); // lu beats jump
    tbl.push_back(mk(0, 8, 0, 0, 1, 1, 8, 1, 1, 0, C_FRZ, 3, 2, 0)); // freeze beats all
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 3, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 3, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_DEF, 3, 2, 0)); // 15 resume
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_DEF, 3, 2, 0)); // ready at once
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, 3, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0)); // freeze x6
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0)); // 20
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_DEF, 0, 0, 1)); // 25
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DEF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_JMP, 0, 0, 1)); // jumps x5
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_JMP, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_JMP, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_JMP, 0, 3, 1)); // 30
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_JMP, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DEF, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RST, 0, 3, 1)); // 35 reset mid wait
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, C_RST, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0)); // fresh wait from 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0)); // 40
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_DEF, 0, 0, 1));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      reset           = tbl[i].rst;
      id_rs           = tbl[i].rs;
      id_rt           = tbl[i].rt;
      id_uses_rt      = tbl[i].urt;
      id_jump         = tbl[i].jmp;
      ex_MemRead      = tbl[i].mrd;
      ex_rt           = tbl[i].xrt;
      ex_branch_taken = tbl[i].br;
      mem_access      = tbl[i].macc;
      dmem_ready      = tbl[i].rdy;
      sb.push_back('{i, tbl[i].ctl, tbl[i].sc, tbl[i].fc, tbl[i].tmo});
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctl", e.idx,
          {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}, e.ctl);
      chk("stall_cnt", e.idx, {4'b0, stall_cnt}, {4'b0, e.sc});
      chk("flush_cnt", e.idx, {4'b0, flush_cnt}, {4'b0, e.fc});
      chk("mem_timeout", e.idx, {5'b0, mem_timeout}, {5'b0, e.tmo});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
